// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared timing constants, framebuffer geometry defaults and
//                the coordinate type for the VGA scan/fetch block.
//                Default timing is 640x480@60 Hz at a 25 MHz pixel rate.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    // Default horizontal timing, in pixels
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;

    // Default vertical timing, in lines
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    // Derived totals and sync windows (inclusive bounds)
    localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;  // 800
    localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;  // 525
    localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;                          // 656
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;                    // 751
    localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;                          // 490
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;                    // 491

    // Framebuffer geometry: IMG_W*IMG_H must fit in 2^ADDR_W
    localparam int IMG_W_DEF    = 250;
    localparam int IMG_H_DEF    = 250;
    localparam int ADDR_W_DEF   = 16;

    typedef logic [9:0] coord_t;

    function automatic coord_t to_coord(input int v);
        return coord_t'(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : vga_delay_line
//  Description : N-stage shift register of width W with a synchronous,
//                active-low reset to RST_VAL on every stage.
//  Ports       : clk - clock
//                rst - synchronous active-low reset
//                d   - input word
//                q   - input word delayed by N clocks
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_delay_line #(
    parameter int             W       = 1,
    parameter int             N       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  d,
    output logic [W-1:0]  q
);

    logic [W-1:0] r_stage [N];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                r_stage[i] <= RST_VAL;
            end
        end else begin
            r_stage[0] <= d;
            for (int i = 1; i < N; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign q = r_stage[N-1];

endmodule
`default_nettype wire

// File: rtl/vga_scan_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : vga_scan_fetch
//  Description : VGA scan generator. Produces the pixel strobe, h/v counters,
//                framebuffer read requests and pipelined coordinates/syncs so
//                that RAM data, the colouring stage's registered RGB and the
//                syncs all line up at the DAC.
//  Ports       : clk         - 50 MHz system clock
//                rst         - synchronous active-low reset
//                pix_tick    - pixel strobe, every second clk
//                x, y        - coordinates aligned with RAM read data
//                video_on    - aligned (x,y) is in the active area
//                hsync/vsync - active-low syncs aligned with registered RGB
//                frame_start - one-clk pulse when counters enter (0,0)
//                mem_addr    - framebuffer read address
//                mem_rd      - read enable, in-image pixels only
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_scan_fetch
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int IMG_W    = IMG_W_DEF,
    parameter int IMG_H    = IMG_H_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic              pix_tick,
    output coord_t            x,
    output coord_t            y,
    output logic              video_on,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd
);

    localparam coord_t            c_h_last   = to_coord(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam coord_t            c_v_last   = to_coord(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam coord_t            c_h_act    = to_coord(H_ACTIVE);
    localparam coord_t            c_v_act    = to_coord(V_ACTIVE);
    localparam coord_t            c_hs_start = to_coord(H_ACTIVE + H_FP);
    localparam coord_t            c_hs_end   = to_coord(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t            c_vs_start = to_coord(V_ACTIVE + V_FP);
    localparam coord_t            c_vs_end   = to_coord(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam coord_t            c_img_w    = to_coord(IMG_W);
    localparam coord_t            c_img_h    = to_coord(IMG_H);
    localparam logic [ADDR_W-1:0] c_row_step = ADDR_W'(IMG_W);

    logic              r_tick;
    coord_t            r_hc;
    coord_t            r_vc;
    logic [ADDR_W-1:0] r_row_base;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_rd;
    logic              r_frame_start;

    logic              w_h_end;
    logic              w_v_end;
    logic              w_active;
    logic              w_in_image;
    logic              w_hs_raw;
    logic              w_vs_raw;
    logic [ADDR_W-1:0] w_addr;
    logic [20:0]       w_pos_q;
    logic [1:0]        w_sync_q;

    assign w_h_end    = (r_hc == c_h_last);
    assign w_v_end    = (r_vc == c_v_last);
    assign w_active   = (r_hc < c_h_act) && (r_vc < c_v_act);
    assign w_in_image = (r_hc < c_img_w) && (r_vc < c_img_h);
    assign w_hs_raw   = !((r_hc >= c_hs_start) && (r_hc <= c_hs_end));
    assign w_vs_raw   = !((r_vc >= c_vs_start) && (r_vc <= c_vs_end));
    // row_base tracks vc*IMG_W incrementally, so no multiplier is needed
    assign w_addr     = r_row_base + ADDR_W'(r_hc);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tick        <= 1'b0;
            r_hc          <= '0;
            r_vc          <= '0;
            r_row_base    <= '0;
            r_mem_addr    <= '0;
            r_mem_rd      <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_tick        <= ~r_tick;
            // Pulse lands in the first clk the counters show (0,0)
            r_frame_start <= r_tick && w_h_end && w_v_end;
            if (r_tick) begin
                if (w_h_end) begin
                    r_hc <= '0;
                    if (w_v_end) begin
                        r_vc       <= '0;
                        r_row_base <= '0;
                    end else begin
                        r_vc <= r_vc + 10'd1;
                        // Stops growing once past the image; unused there
                        if (r_vc < c_img_h) begin
                            r_row_base <= r_row_base + c_row_step;
                        end
                    end
                end else begin
                    r_hc <= r_hc + 10'd1;
                end
            end
            r_mem_rd   <= w_in_image;
            r_mem_addr <= w_in_image ? w_addr : '0;
        end
    end

    // Coordinates meet RAM data two clks after the counters
    vga_delay_line #(
        .W       (21),
        .N       (2),
        .RST_VAL (21'd0)
    ) u_pos_dly (
        .clk (clk),
        .rst (rst),
        .d   ({w_active, r_hc, r_vc}),
        .q   (w_pos_q)
    );

    // Syncs wait one extra clk for the colouring stage's RGB register
    vga_delay_line #(
        .W       (2),
        .N       (3),
        .RST_VAL (2'b11)
    ) u_sync_dly (
        .clk (clk),
        .rst (rst),
        .d   ({w_hs_raw, w_vs_raw}),
        .q   (w_sync_q)
    );

    assign pix_tick    = r_tick;
    assign video_on    = w_pos_q[20];
    assign x           = w_pos_q[19:10];
    assign y           = w_pos_q[9:0];
    assign hsync       = w_sync_q[1];
    assign vsync       = w_sync_q[0];
    assign frame_start = r_frame_start;
    assign mem_addr    = r_mem_addr;
    assign mem_rd      = r_mem_rd;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_scan_fetch
//  Description : Directed testbench. u_full uses the 640x480 defaults; u_small
//                uses a shrunken geometry (24x17 totals, 10x8 image) so that
//                vertical timing and frame pulses fit in a short run.
//                n counts clk edges since the last reset edge; the values
//                checked are taken after edge n (sampled on the negedge).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_scan_fetch;

    logic        clk;
    logic        rst;

    logic        tick_f, von_f, hs_f, vs_f, fs_f, rd_f;
    logic [9:0]  x_f, y_f;
    logic [15:0] addr_f;

    logic        tick_s, von_s, hs_s, vs_s, fs_s, rd_s;
    logic [9:0]  x_s, y_s;
    logic [7:0]  addr_s;

    logic [7:0]  ram_q;
    int          n;
    int          cnt_fs_s, last_fs_s, cnt_fs_f;
    int          checks;
    int          errors;

    vga_scan_fetch u_full (
        .clk (clk), .rst (rst), .pix_tick (tick_f), .x (x_f), .y (y_f),
        .video_on (von_f), .hsync (hs_f), .vsync (vs_f), .frame_start (fs_f),
        .mem_addr (addr_f), .mem_rd (rd_f)
    );

    vga_scan_fetch #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (2),
        .V_ACTIVE (12), .V_FP (1), .V_SYNC (2), .V_BP (2),
        .IMG_W (10), .IMG_H (8), .ADDR_W (8)
    ) u_small (
        .clk (clk), .rst (rst), .pix_tick (tick_s), .x (x_s), .y (y_s),
        .video_on (von_s), .hsync (hs_s), .vsync (vs_s), .frame_start (fs_s),
        .mem_addr (addr_s), .mem_rd (rd_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model with 1-clk latency: data = low 8 address bits
    always @(posedge clk) ram_q <= addr_f[7:0];

    // Edge counter and frame_start pulse monitor
    always @(posedge clk) begin
        if (!rst) begin
            n        <= 0;
            cnt_fs_s <= 0;
            cnt_fs_f <= 0;
            last_fs_s <= -1;
        end else begin
            n <= n + 1;
            if (fs_s === 1'b1) begin
                cnt_fs_s  <= cnt_fs_s + 1;
                last_fs_s <= n;
            end
            if (fs_f === 1'b1) cnt_fs_f <= cnt_fs_f + 1;
        end
    end

    task automatic wait_n(input int t);
        int guard;
        guard = 0;
        while (n < t && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (tick_f !== 1'b0) begin errors++; $display("FAIL reset_pix_tick: got %0b expected 0", tick_f); end
        checks++; if (x_f !== 10'd0) begin errors++; $display("FAIL reset_x: got %0d expected 0", x_f); end
        checks++; if (y_f !== 10'd0) begin errors++; $display("FAIL reset_y: got %0d expected 0", y_f); end
        checks++; if (von_f !== 1'b0) begin errors++; $display("FAIL reset_video_on: got %0b expected 0", von_f); end
        checks++; if (hs_f !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %0b expected 1", hs_f); end
        checks++; if (vs_f !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %0b expected 1", vs_f); end
        checks++; if (addr_f !== 16'd0) begin errors++; $display("FAIL reset_mem_addr: got %0d expected 0", addr_f); end
        checks++; if (rd_f !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %0b expected 0", rd_f); end
        checks++; if (fs_f !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %0b expected 0", fs_f); end
        checks++; if (hs_s !== 1'b1 || vs_s !== 1'b1) begin errors++; $display("FAIL reset_small_syncs: got %0b%0b expected 11", hs_s, vs_s); end
        rst = 1'b1;
        wait_n(1);
        checks++; if (tick_f !== 1'b1) begin errors++; $display("FAIL first_tick: got %0b expected 1", tick_f); end
        checks++; if (rd_f !== 1'b1 || addr_f !== 16'd0) begin errors++; $display("FAIL addr_0_0: got rd=%0b addr=%0d expected rd=1 addr=0", rd_f, addr_f); end
        checks++; if (rd_s !== 1'b1 || addr_s !== 8'd0) begin errors++; $display("FAIL small_addr_0_0: got rd=%0b addr=%0d expected rd=1 addr=0", rd_s, addr_s); end
        wait_n(2);
        checks++; if (tick_f !== 1'b0) begin errors++; $display("FAIL second_tick: got %0b expected 0", tick_f); end
        checks++; if (von_f !== 1'b1 || x_f !== 10'd0) begin errors++; $display("FAIL first_video_on: got von=%0b x=%0d expected von=1 x=0", von_f, x_f); end
    endtask

    task automatic test_small_image_edge;
        wait_n(337);
        checks++; if (rd_s !== 1'b1 || addr_s !== 8'd70) begin errors++; $display("FAIL small_addr_0_7: got rd=%0b addr=%0d expected rd=1 addr=70", rd_s, addr_s); end
        wait_n(355);
        checks++; if (rd_s !== 1'b1 || addr_s !== 8'd79) begin errors++; $display("FAIL small_addr_9_7: got rd=%0b addr=%0d expected rd=1 addr=79", rd_s, addr_s); end
        wait_n(356);
        checks++; if (x_s !== 10'd9 || y_s !== 10'd7 || von_s !== 1'b1) begin errors++; $display("FAIL small_xy_9_7: got x=%0d y=%0d von=%0b expected 9 7 1", x_s, y_s, von_s); end
        wait_n(357);
        checks++; if (rd_s !== 1'b0 || addr_s !== 8'd0) begin errors++; $display("FAIL small_addr_10_7: got rd=%0b addr=%0d expected rd=0 addr=0", rd_s, addr_s); end
        wait_n(385);
        checks++; if (rd_s !== 1'b0 || addr_s !== 8'd0) begin errors++; $display("FAIL small_addr_0_8: got rd=%0b addr=%0d expected rd=0 addr=0", rd_s, addr_s); end
    endtask

    task automatic test_address_row0;
        wait_n(499);
        checks++; if (rd_f !== 1'b1 || addr_f !== 16'd249) begin errors++; $display("FAIL addr_249_0: got rd=%0b addr=%0d expected rd=1 addr=249", rd_f, addr_f); end
        wait_n(501);
        checks++; if (rd_f !== 1'b0 || addr_f !== 16'd0) begin errors++; $display("FAIL addr_250_0: got rd=%0b addr=%0d expected rd=0 addr=0", rd_f, addr_f); end
    endtask

    task automatic test_vsync(input string tag);
        int cnt;
        wait_n(626);
        checks++; if (vs_s !== 1'b1) begin errors++; $display("FAIL %s_vsync_before: got %0b expected 1", tag, vs_s); end
        wait_n(627);
        checks++; if (vs_s !== 1'b0) begin errors++; $display("FAIL %s_vsync_fall: got %0b expected 0", tag, vs_s); end
        checks++; if (vs_f !== 1'b1) begin errors++; $display("FAIL %s_full_vsync_idle: got %0b expected 1", tag, vs_f); end
        cnt = 0;
        while (vs_s === 1'b0 && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        checks++; if (cnt != 96) begin errors++; $display("FAIL %s_vsync_width: got %0d expected 96", tag, cnt); end
    endtask

    task automatic test_frame_start(input int at_n, input int exp_cnt, input int exp_last, input string tag);
        wait_n(at_n);
        checks++; if (cnt_fs_s != exp_cnt || last_fs_s != exp_last) begin errors++; $display("FAIL %s_frame_start: got count=%0d at=%0d expected count=%0d at=%0d", tag, cnt_fs_s, last_fs_s, exp_cnt, exp_last); end
        checks++; if (cnt_fs_f != 0) begin errors++; $display("FAIL %s_full_frame_start: got count=%0d expected 0", tag, cnt_fs_f); end
    endtask

    task automatic test_hsync(input string tag);
        int cnt;
        wait_n(1314);
        checks++; if (hs_f !== 1'b1) begin errors++; $display("FAIL %s_hsync_before: got %0b expected 1", tag, hs_f); end
        wait_n(1315);
        checks++; if (hs_f !== 1'b0) begin errors++; $display("FAIL %s_hsync_fall: got %0b expected 0", tag, hs_f); end
        cnt = 0;
        while (hs_f === 1'b0 && cnt < 400) begin
            cnt++;
            @(negedge clk);
        end
        checks++; if (cnt != 192) begin errors++; $display("FAIL %s_hsync_width: got %0d expected 192", tag, cnt); end
    endtask

    task automatic test_address_row1;
        wait_n(1601);
        checks++; if (rd_f !== 1'b1 || addr_f !== 16'd250) begin errors++; $display("FAIL addr_0_1: got rd=%0b addr=%0d expected rd=1 addr=250", rd_f, addr_f); end
    endtask

    task automatic test_line_period;
        int   fall_n;
        int   guard;
        logic prev;
        fall_n = -1;
        guard  = 0;
        prev   = hs_f;
        while (fall_n < 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
            if (prev === 1'b1 && hs_f === 1'b0) fall_n = n;
            prev = hs_f;
        end
        checks++; if (fall_n != 2915) begin errors++; $display("FAIL line_period: got fall at %0d expected 2915", fall_n); end
    endtask

    task automatic test_alignment;
        wait_n(4835);
        checks++; if (rd_f !== 1'b1 || addr_f !== 16'd767) begin errors++; $display("FAIL addr_17_3: got rd=%0b addr=%0d expected rd=1 addr=767", rd_f, addr_f); end
        wait_n(4836);
        checks++; if (x_f !== 10'd17 || y_f !== 10'd3) begin errors++; $display("FAIL align_xy: got x=%0d y=%0d expected 17 3", x_f, y_f); end
        checks++; if (ram_q !== 8'd255) begin errors++; $display("FAIL align_ram_data: got %0d expected 255", ram_q); end
        checks++; if (von_f !== 1'b1) begin errors++; $display("FAIL align_video_on: got %0b expected 1", von_f); end
    endtask

    task automatic test_mid_reset;
        wait_n(5400);
        checks++; if (u_small.r_hc !== 10'd12 || u_small.r_vc !== 10'd10) begin errors++; $display("FAIL pre_reset_pos: got hc=%0d vc=%0d expected 12 10", u_small.r_hc, u_small.r_vc); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++; if (u_small.r_hc !== 10'd0 || u_small.r_vc !== 10'd0 || u_small.r_row_base !== 8'd0) begin errors++; $display("FAIL mid_reset_small_state: got hc=%0d vc=%0d rb=%0d expected 0 0 0", u_small.r_hc, u_small.r_vc, u_small.r_row_base); end
        checks++; if (u_full.r_hc !== 10'd0 || u_full.r_vc !== 10'd0 || u_full.r_row_base !== 16'd0) begin errors++; $display("FAIL mid_reset_full_state: got hc=%0d vc=%0d rb=%0d expected 0 0 0", u_full.r_hc, u_full.r_vc, u_full.r_row_base); end
        checks++; if (tick_f !== 1'b0 || rd_f !== 1'b0 || von_f !== 1'b0 || hs_f !== 1'b1 || fs_f !== 1'b0) begin errors++; $display("FAIL mid_reset_outputs: got tick=%0b rd=%0b von=%0b hs=%0b fs=%0b expected 0 0 0 1 0", tick_f, rd_f, von_f, hs_f, fs_f); end
        checks++; if (addr_f !== 16'd0 || x_f !== 10'd0 || y_f !== 10'd0) begin errors++; $display("FAIL mid_reset_addr_xy: got addr=%0d x=%0d y=%0d expected 0 0 0", addr_f, x_f, y_f); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        test_reset();
        test_small_image_edge();
        test_address_row0();
        test_vsync("f1");
        test_frame_start(900, 1, 816, "f1");
        test_hsync("f1");
        test_address_row1();
        test_frame_start(1700, 2, 1632, "f2");
        test_line_period();
        test_alignment();
        test_mid_reset();
        test_vsync("rst");
        test_frame_start(900, 1, 816, "rst");
        test_hsync("rst");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
